ggt_euclid: RTL and testbench
=============================

Name: ggt_euclid

Overview:
- Sequential 16-bit greatest-common-divisor (ggT) unit using the subtractive Euclid algorithm, one subtraction per clock.
- Operands are captured on a start pulse. Completion is flagged with a level `valid_o`, and the result is held until the next completion.
- Sits between operand sources and a result sink. For example, on FPGA the result is written into a single-word memory using `valid_o` as the write enable.

Parameters:
- WIDTH, 16, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  request a computation; sampled on the rising edge.
- Zahl1_i  input  WIDTH  first operand (unsigned).
- Zahl2_i  input  WIDTH  second operand (unsigned).
- valid_o  output  1  high while `ergebnis_o` holds the result of the most recent computation.
- ergebnis_o  output  WIDTH  ggT result.

Behaviour:
- Reset (`rst_i` low, asynchronous):
  - state = IDLE, internal registers A = B = 0.
  - `valid_o` = 0, `ergebnis_o` = 0.
  - Reset mid-computation aborts it with no result.
- States: IDLE, CALC, DONE.
- IDLE or DONE with `start_i` = 1 at a clock edge:
  - A <= `Zahl1_i`, B <= `Zahl2_i`.
  - `valid_o` <= 0.
  - state <= CALC.
  - `ergebnis_o` keeps its old value.
- IDLE or DONE with `start_i` = 0: hold all state.
- CALC, one of the following per edge, in priority order:
  - B == 0: `ergebnis_o` <= A, go to DONE.
  - A == 0: `ergebnis_o` <= B, go to DONE.
  - A == B: `ergebnis_o` <= A, go to DONE.
  - A > B: A <= A − B.
  - otherwise: B <= B − A.
- `start_i` during CALC is ignored. Operands are not re-sampled; input changes after the capture edge have no effect.
- DONE: `valid_o` = 1 (registered, asserted on the edge entering DONE) and stays high until the next accepted start or reset.
- Continuous operation: if `start_i` is held high permanently, each completion immediately restarts a computation. `valid_o` is then high for exactly one cycle per result.
- Latency: 1 capture edge + k subtraction edges + 1 finishing edge.
  - Equal operands: `valid_o` is high after the 2nd edge.
  - Worst case (65535, 1): about 65536 cycles.
- Arithmetic: unsigned. Subtraction always takes the larger minus the smaller, so there is no underflow.
- Boundary results:
  - ggT(0, b) = b.
  - ggT(a, 0) = a.
  - ggT(0, 0) = 0.
  - Each of these completes on the first CALC edge.
- `ergebnis_o` changes only on the edge that enters DONE.

Decomposition:
- Shared package ggt_pkg:
  - WIDTH default constant.
  - state enum type (IDLE, CALC, DONE).
- One sub-module is natural: ggt_step.
  - Combinational: takes A and B.
  - Returns next A, next B, a done flag and the result, implementing the CALC priority rules.
- The top level holds the FSM, operand registers and output registers.

Test Plan:
- Reset: hold `rst_i` low for 2 cycles, release -> `valid_o` = 0, `ergebnis_o` = 0. Assert `rst_i` low mid-CALC with (65535, 1) -> outputs return to 0 immediately (asynchronous) and no `valid_o` pulse follows.
- Equal operands: (180, 180), 1-cycle start -> `valid_o` rises on the 2nd edge after the start edge, `ergebnis_o` = 180.
- Normal cases, each with `valid_o` low from the start-capture edge until done:
  - (12, 8) -> 4 after 4 edges.
  - (24255, 12540) -> 165.
  - (17, 5) -> 1.
- Zeros:
  - (0, 42) -> 42.
  - (42, 0) -> 42.
  - (0, 0) -> 0.
  - Each completes on the 2nd edge.
- Back-to-back via file-style loop: pulse start, wait for `valid_o`, record result, change operands, pulse start again -> `valid_o` drops on the capture edge and each result matches a software ggT reference. Operand changes and a start pulse issued during CALC are ignored.
- Start held high constantly with (180, 180) -> `valid_o` pulses high for 1 of every 2 cycles, `ergebnis_o` is constantly 180.

Source files
------------

// File: rtl/ggt_pkg.sv
// Shared definitions for the subtractive-Euclid ggT unit:
// default operand width and the controller state type.
package ggt_pkg;

    localparam int GGT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ggt_step.sv
// One subtractive Euclid step: decides between finishing and subtracting
// the smaller operand from the larger one.
module ggt_step #(
    parameter int WIDTH = ggt_pkg::GGT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] a_next_o,
    output logic [WIDTH-1:0] b_next_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    always_comb begin
        a_next_o = a_i;
        b_next_o = b_i;
        done_o   = 1'b0;
        result_o = a_i;
        // Zero checks come first so ggT(0,b)=b and ggT(a,0)=a finish at once.
        if (b_i == '0) begin
            done_o   = 1'b1;
            result_o = a_i;
        end else if (a_i == '0) begin
            done_o   = 1'b1;
            result_o = b_i;
        end else if (a_i == b_i) begin
            done_o   = 1'b1;
            result_o = a_i;
        end else if (a_i > b_i) begin
            a_next_o = a_i - b_i;
        end else begin
            b_next_o = b_i - a_i;
        end
    end

endmodule

// File: rtl/ggt_euclid.sv
// Sequential ggT unit: captures two operands on start, runs one subtraction
// per clock and holds the result with a level valid flag until the next start.
module ggt_euclid
    import ggt_pkg::*;
#(
    parameter int WIDTH = GGT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] Zahl1_i,
    input  logic [WIDTH-1:0] Zahl2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] ergebnis_o
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   ergebnis_q, ergebnis_d;

    logic [WIDTH-1:0]   step_a;
    logic [WIDTH-1:0]   step_b;
    logic               step_done;
    logic [WIDTH-1:0]   step_result;

    ggt_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i      (a_q),
        .b_i      (b_q),
        .a_next_o (step_a),
        .b_next_o (step_b),
        .done_o   (step_done),
        .result_o (step_result)
    );

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            valid_q    <= 1'b0;
            ergebnis_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            valid_q    <= valid_d;
            ergebnis_q <= ergebnis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_i)   state_d = CALC;
            CALC:       if (step_done) state_d = DONE;
            default:                   state_d = IDLE;
        endcase
    end

    // start_i is only honoured outside CALC, so late operand changes are inert.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        valid_d    = valid_q;
        ergebnis_d = ergebnis_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    a_d     = Zahl1_i;
                    b_d     = Zahl2_i;
                    valid_d = 1'b0;
                end
            end
            CALC: begin
                if (step_done) begin
                    ergebnis_d = step_result;
                    valid_d    = 1'b1;
                end else begin
                    a_d = step_a;
                    b_d = step_b;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    assign valid_o    = valid_q;
    assign ergebnis_o = ergebnis_q;

endmodule

// File: tb/tb_ggt_euclid.sv
// Scoreboard bench for ggt_euclid: the driver queues expected results from a
// modulo-based ggT model, a negedge monitor checks each completion.
module tb_ggt_euclid;

    localparam int W = 16;

    logic         clk;
    logic         rst_i;
    logic         start_i;
    logic [W-1:0] Zahl1_i;
    logic [W-1:0] Zahl2_i;
    logic         valid_o;
    logic [W-1:0] ergebnis_o;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        int           cap;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           mon_en = 1'b1;
    logic         valid_prev = 1'b0;
    logic [W-1:0] last_res = '0;

    ggt_euclid #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .Zahl1_i    (Zahl1_i),
        .Zahl2_i    (Zahl2_i),
        .valid_o    (valid_o),
        .ergebnis_o (ergebnis_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_ggt(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x[W-1:0];
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every rising valid_o must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en && valid_o && !valid_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", ergebnis_o, e.res);
                $display("result %0d expected %0d latency %0d", ergebnis_o, e.res, cyc - e.cap + 1);
                if (e.lat > 0) check("latency", cyc - e.cap + 1, e.lat);
            end
        end
        valid_prev = valid_o;
    end

    task automatic wait_valid(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        if (!seen) check("timeout", 0, 1);
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int lat, input bit perturb);
        exp_t e;
        @(negedge clk);
        Zahl1_i = a;
        Zahl2_i = b;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        e.res = ref_ggt(a, b);
        e.lat = lat;
        e.cap = cyc;
        sb_q.push_back(e);
        $display("start a=%0d b=%0d", a, b);
        check("valid_drop", valid_o, 0);
        check("result_hold", ergebnis_o, last_res);
        if (perturb) begin
            // Spurious start and new operands on the first CALC edge.
            Zahl1_i = W'($urandom);
            Zahl2_i = W'($urandom);
            start_i = 1'b1;
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        wait_valid(5000);
        last_res = e.res;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int highs;
        logic pv;

        rst_i   = 1'b0;
        start_i = 1'b0;
        Zahl1_i = '0;
        Zahl2_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        check("reset_valid", valid_o, 0);
        check("reset_result", ergebnis_o, 0);

        run_one(16'd180, 16'd180, 2, 1'b0);
        run_one(16'd12, 16'd8, 4, 1'b0);
        run_one(16'd24255, 16'd12540, 0, 1'b0);
        run_one(16'd17, 16'd5, 0, 1'b0);
        run_one(16'd0, 16'd42, 2, 1'b0);
        run_one(16'd42, 16'd0, 2, 1'b0);
        run_one(16'd0, 16'd0, 2, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom_range(0, 1023));
            rb = W'($urandom_range(0, 1023));
            run_one(ra, rb, 0, 1'b1);
        end

        // Asynchronous abort of a long computation.
        @(negedge clk);
        Zahl1_i = 16'd65535;
        Zahl2_i = 16'd1;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_i = 1'b0;
        #1;
        check("async_rst_valid", valid_o, 0);
        check("async_rst_result", ergebnis_o, 0);
        @(negedge clk);
        rst_i = 1'b1;
        last_res = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid_o) check("no_valid_after_abort", valid_o, 0);
        end
        check("no_valid_after_abort", valid_o, 0);

        run_one(16'd35, 16'd21, 0, 1'b0);

        // Continuous start: one-cycle valid per result, constant 180.
        mon_en = 1'b0;
        @(negedge clk);
        Zahl1_i = 16'd180;
        Zahl2_i = 16'd180;
        start_i = 1'b1;
        repeat (3) @(negedge clk);
        highs = 0;
        pv = valid_o;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("cont_toggle", valid_o, !pv);
            check("cont_result", ergebnis_o, 180);
            if (valid_o) highs++;
            pv = valid_o;
        end
        check("cont_high_count", highs, 6);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
